// File: rtl/riscv_mem_pkg.sv
// Shared memory-access definitions for the RISC-V load/store paths.
// Holds the mem_rw encodings, the lane count and the store FSM state type.
package riscv_mem_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [3:0] MEM_W  = 4'b0000;
    localparam logic [3:0] MEM_H  = 4'b0001;
    localparam logic [3:0] MEM_B  = 4'b0010;
    localparam logic [3:0] MEM_HU = 4'b0100;
    localparam logic [3:0] MEM_BU = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } store_state_t;

    // Only the signed-agnostic widths can be stored; HU/BU are load-only codes.
    function automatic logic is_store_type(input logic [3:0] rw);
        return (rw == MEM_W) || (rw == MEM_H) || (rw == MEM_B);
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational byte-lane generator for stores.
// Produces the in-word beat and the spill beat (the bytes that fall past the
// word boundary) for a given store type, byte offset and LSB-justified data.
module store_lane_gen
    import riscv_mem_pkg::*;
(
    input  logic [3:0]           mem_rw,
    input  logic [1:0]           off,
    input  logic [31:0]          data,
    output logic [NUM_LANES-1:0] we_lo,
    output logic [31:0]          din_lo,
    output logic [NUM_LANES-1:0] we_hi,
    output logic [31:0]          din_hi,
    output logic                 needs_spill,
    output logic                 valid_type
);

    logic [NUM_LANES-1:0] mask;
    logic [31:0]          src;
    logic [4:0]           lo_shift;
    logic [5:0]           hi_shift;

    // Build the lane mask and source bytes, then shift them into place for both beats.
    always_comb begin
        mask        = '0;
        src         = '0;
        valid_type  = is_store_type(mem_rw);
        lo_shift    = {off, 3'b000};
        hi_shift    = 6'd32 - {1'b0, off, 3'b000};
        case (mem_rw)
            MEM_W: begin
                mask = 4'b1111;
                src  = data;
            end
            MEM_H: begin
                mask = 4'b0011;
                src  = {16'h0000, data[15:0]};
            end
            MEM_B: begin
                mask = 4'b0001;
                src  = {24'h000000, data[7:0]};
            end
            default: begin
                mask = '0;
                src  = '0;
            end
        endcase
        we_lo       = mask << off;
        din_lo      = src << lo_shift;
        we_hi       = mask >> (3'd4 - {1'b0, off});
        din_hi      = src >> hi_shift;
        needs_spill = ((mem_rw == MEM_W) && (off != 2'd0)) ||
                      ((mem_rw == MEM_H) && (off == 2'd3));
    end

endmodule

// File: rtl/store_unit.sv
// Store-side data path: accepts SW/SH/SB requests, aligns them onto byte lanes
// and drives a valid/ready word-addressed write port, splitting stores that
// cross a word boundary into two beats.
// Optional macro STORE_MISALIGN_EXC_EN: misaligned stores are rejected and
// reported on store_misalign instead of being split.
module store_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_mem_rw,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_din,
    output logic [NUM_LANES-1:0] mem_we,
    output logic                 store_done,
`ifdef STORE_MISALIGN_EXC_EN
    output logic                 store_misalign,
`endif
    output logic                 busy
);

    store_state_t         state;
    store_state_t         state_next;

    logic [NUM_LANES-1:0] lane_we_lo;
    logic [31:0]          lane_din_lo;
    logic [NUM_LANES-1:0] lane_we_hi;
    logic [31:0]          lane_din_hi;
    logic                 lane_needs_spill;
    logic                 lane_valid_type;

    logic [ADDR_W-1:0]    word_addr;
    logic [ADDR_W-1:0]    next_word_addr;
    logic                 accept;
    logic                 reject;

    logic [ADDR_W-1:0]    hi_addr;
    logic [31:0]          hi_din;
    logic [NUM_LANES-1:0] hi_we;
    logic                 spill_pending;

    logic                 load_beat0;
    logic                 load_beat1;
    logic                 go_idle;
    logic                 done_next;

`ifdef STORE_MISALIGN_EXC_EN
    logic                 misaligned;
    logic                 misalign_next;
`endif

    store_lane_gen u_lane_gen (
        .mem_rw      (req_mem_rw),
        .off         (req_addr[1:0]),
        .data        (req_data[31:0]),
        .we_lo       (lane_we_lo),
        .din_lo      (lane_din_lo),
        .we_hi       (lane_we_hi),
        .din_hi      (lane_din_hi),
        .needs_spill (lane_needs_spill),
        .valid_type  (lane_valid_type)
    );

    assign word_addr      = {req_addr[ADDR_W-1:2], 2'b00};
    assign next_word_addr = word_addr + ADDR_W'(4);

    assign req_ready = (state == ST_IDLE);
    assign mem_valid = (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;

`ifdef STORE_MISALIGN_EXC_EN
    // Word stores must be word aligned and halfword stores halfword aligned.
    assign misaligned = ((req_mem_rw == MEM_W) && (req_addr[1:0] != 2'd0)) ||
                        ((req_mem_rw == MEM_H) && req_addr[0]);
    assign reject     = !lane_valid_type || misaligned;
`else
    assign reject     = !lane_valid_type;
`endif

    // State register; reset abandons any in-flight beat including a pending spill.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode for the beat sequencer.
    always_comb begin
        state_next = state;
        load_beat0 = 1'b0;
        load_beat1 = 1'b0;
        go_idle    = 1'b0;
        done_next  = 1'b0;
`ifdef STORE_MISALIGN_EXC_EN
        misalign_next = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        done_next = 1'b1;
`ifdef STORE_MISALIGN_EXC_EN
                        misalign_next = lane_valid_type && misaligned;
`endif
                    end else begin
                        load_beat0 = 1'b1;
                        state_next = ST_BEAT0;
                    end
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
                    if (spill_pending) begin
                        load_beat1 = 1'b1;
                        state_next = ST_BEAT1;
                    end else begin
                        go_idle    = 1'b1;
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_BEAT1: begin
                if (mem_ready) begin
                    go_idle    = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                go_idle    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    // Beat registers: load beat0 plus the spill on accept, swap in the spill, clear enables when done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_addr      <= '0;
            mem_din       <= '0;
            mem_we        <= '0;
            hi_addr       <= '0;
            hi_din        <= '0;
            hi_we         <= '0;
            spill_pending <= 1'b0;
            store_done    <= 1'b0;
        end else begin
            store_done <= done_next;
            if (load_beat0) begin
                mem_addr      <= word_addr;
                mem_din       <= lane_din_lo;
                mem_we        <= lane_we_lo;
                hi_addr       <= next_word_addr;
                hi_din        <= lane_din_hi;
                hi_we         <= lane_we_hi;
                spill_pending <= lane_needs_spill;
            end else if (load_beat1) begin
                mem_addr      <= hi_addr;
                mem_din       <= hi_din;
                mem_we        <= hi_we;
                spill_pending <= 1'b0;
            end else if (go_idle) begin
                mem_we        <= '0;
                spill_pending <= 1'b0;
            end
        end
    end

`ifdef STORE_MISALIGN_EXC_EN
    // Misalignment flag pulses alongside store_done for a rejected request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            store_misalign <= 1'b0;
        end else begin
            store_misalign <= misalign_next;
        end
    end
`endif

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: scoreboard of expected write beats checked by a
// monitor on the falling edge, driven by a linear sequence of directed steps.
// Honors STORE_MISALIGN_EXC_EN to select the matching set of steps.
module tb_store_unit;
    import riscv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_mem_rw = 4'b0000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic        store_done;
    logic        busy;
`ifdef STORE_MISALIGN_EXC_EN
    logic        store_misalign;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  we;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    logic  done_expect = 1'b0;

    store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mem_rw (req_mem_rw),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .store_done (store_done),
`ifdef STORE_MISALIGN_EXC_EN
        .store_misalign (store_misalign),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic l);
        beat_t b;
        b.addr = a;
        b.din  = d;
        b.we   = w;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic send_req(input logic [3:0] rw, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            n_err++;
            $display("[TB] FAIL req_ready_timeout: observed=0 expected=1");
        end
        req_valid  = 1'b1;
        req_mem_rw = rw;
        req_addr   = a;
        req_data   = d;
        @(posedge clk); #1;
        req_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy && exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic        prev_stall = 1'b0;
    logic        expect_valid = 1'b0;
    logic [31:0] held_addr;
    logic [31:0] held_din;
    logic [3:0]  held_we;

    // Monitor: done timing, hold stability, no-bubble and scoreboard compare on each handshake.
    always @(negedge clk) begin
        if (!resetn) begin
            check("done_in_reset", 32'(store_done), 32'd0);
            prev_stall   = 1'b0;
            expect_valid = 1'b0;
            done_expect  = 1'b0;
        end else begin
            check("store_done", 32'(store_done), 32'(done_expect));
            done_expect = 1'b0;
            if (!mem_valid) check("we_when_idle", 32'(mem_we), 32'd0);
            if (prev_stall) begin
                check("hold_valid", 32'(mem_valid), 32'd1);
                check("hold_addr", mem_addr, held_addr);
                check("hold_din", mem_din, held_din);
                check("hold_we", 32'(mem_we), 32'(held_we));
            end
            if (expect_valid) check("no_bubble", 32'(mem_valid), 32'd1);
            prev_stall   = 1'b0;
            expect_valid = 1'b0;
            if (mem_valid && !mem_ready) begin
                prev_stall = 1'b1;
                held_addr  = mem_addr;
                held_din   = mem_din;
                held_we    = mem_we;
            end
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL unexpected_beat: observed addr=0x%08h we=%b expected no beat", mem_addr, mem_we);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_addr", mem_addr, e.addr);
                    check("beat_din", mem_din, e.din);
                    check("beat_we", 32'(mem_we), 32'(e.we));
                    if (e.last) done_expect = 1'b1;
                    else        expect_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_store_done", 32'(store_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b1;

        push(32'h0000_1000, 32'hAB00_0000, 4'b1000, 1'b1);
        send_req(MEM_B, 32'h0000_1003, 32'h0000_00AB);
        wait_idle("sb_1003");

        push(32'h0000_2000, 32'h1234_0000, 4'b1100, 1'b1);
        send_req(MEM_H, 32'h0000_2002, 32'h0000_1234);
        wait_idle("sh_2002");

        push(32'h0000_4000, 32'h1234_5678, 4'b1111, 1'b1);
        send_req(MEM_W, 32'h0000_4000, 32'h1234_5678);
        wait_idle("sw_4000");

        push(32'h0000_5000, 32'h0000_5A00, 4'b0010, 1'b1);
        send_req(MEM_B, 32'h0000_5001, 32'hFFFF_FF5A);
        wait_idle("sb_5001");

        send_req(MEM_HU, 32'h0000_6000, 32'h0000_FFFF);
        done_expect = 1'b1;
        check("unsup_busy", 32'(busy), 32'd0);
        check("unsup_valid", 32'(mem_valid), 32'd0);
        wait_idle("unsup");
        @(posedge clk); #1;

`ifndef STORE_MISALIGN_EXC_EN
        push(32'h0000_3000, 32'hCCBB_AA00, 4'b1110, 1'b0);
        push(32'h0000_3004, 32'h0000_00DD, 4'b0001, 1'b1);
        send_req(MEM_W, 32'h0000_3001, 32'hDDCC_BBAA);
        wait_idle("sw_3001");

        push(32'h0000_2000, 32'hEF00_0000, 4'b1000, 1'b0);
        push(32'h0000_2004, 32'h0000_00BE, 4'b0001, 1'b1);
        send_req(MEM_H, 32'h0000_2003, 32'h5555_BEEF);
        wait_idle("sh_2003");

        mem_ready = 1'b0;
        push(32'hFFFF_FFFC, 32'h3344_0000, 4'b1100, 1'b0);
        push(32'h0000_0000, 32'h0000_1122, 4'b0011, 1'b1);
        send_req(MEM_W, 32'hFFFF_FFFE, 32'h1122_3344);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_b0", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_b1", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after", 32'(req_ready), 32'd1);
        wait_idle("bp_wrap");

        mem_ready = 1'b0;
        push(32'h0000_3000, 32'hCCBB_AA00, 4'b1110, 1'b0);
        send_req(MEM_W, 32'h0000_3001, 32'hDDCC_BBAA);
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_valid", 32'(mem_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        @(posedge clk); #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        push(32'h0000_1000, 32'hAB00_0000, 4'b1000, 1'b1);
        send_req(MEM_B, 32'h0000_1003, 32'h0000_00AB);
        wait_idle("post_reset");
`else
        send_req(MEM_W, 32'h0000_3001, 32'hDDCC_BBAA);
        done_expect = 1'b1;
        check("mis_sw_flag", 32'(store_misalign), 32'd1);
        check("mis_sw_done", 32'(store_done), 32'd1);
        check("mis_sw_valid", 32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        check("mis_sw_flag_clr", 32'(store_misalign), 32'd0);
        check("mis_sw_done_clr", 32'(store_done), 32'd0);

        send_req(MEM_H, 32'h0000_2001, 32'h0000_1234);
        done_expect = 1'b1;
        check("mis_sh_flag", 32'(store_misalign), 32'd1);
        check("mis_sh_valid", 32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        check("mis_sh_flag_clr", 32'(store_misalign), 32'd0);

        push(32'h0000_2000, 32'h1234_0000, 4'b1100, 1'b1);
        send_req(MEM_H, 32'h0000_2002, 32'h0000_1234);
        check("aligned_sh_flag", 32'(store_misalign), 32'd0);
        wait_idle("mis_aligned_sh");
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
